// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage. Owns the PC and the IF/ID pipeline
//               register, handles redirects that arrive while instruction
//               memory is busy, and optionally freezes on opcode 5'b00000
//               when the FETCH_HALT_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pc_sel,
  input  logic [15:0] pc_jump_out,
  input  logic [15:0] imem_instr,
  input  logic        imem_stall,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  output logic [15:0] instr_IF_ID,
  output logic [15:0] pc_add2_IF_ID,
  output logic        valid_IF_ID,
  output logic        halted
);

  localparam logic [15:0] C_NOP_INSTR = 16'h0800;
  localparam logic [15:0] C_PC_RESET  = 16'h0000;
  localparam logic [15:0] C_PC_STEP   = 16'd2;

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    HALTED = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1
  } state_t;
`endif

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_pend_tgt;
  logic [15:0] r_instr;
  logic [15:0] r_pc_add2;
  logic        r_valid;

  logic        w_redirect;
  logic [15:0] w_pc_add2;

  // A jump is only honoured when the instruction that produced it is real
  // and is actually leaving IF/ID this cycle.
  assign w_redirect = pc_sel & r_valid & ~stall;
  assign w_pc_add2  = r_pc + C_PC_STEP;

`ifdef FETCH_HALT_EN
  logic w_halt_req;
  logic r_halted;

  assign w_halt_req = r_valid & (r_instr[15:11] == 5'b00000) & ~stall;
  assign halted     = r_halted;
  assign imem_rd    = ~rst & (r_state != HALTED);
`else
  assign halted     = 1'b0;
  assign imem_rd    = ~rst;
`endif

  assign imem_addr     = r_pc;
  assign instr_IF_ID   = r_instr;
  assign pc_add2_IF_ID = r_pc_add2;
  assign valid_IF_ID   = r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_pc       <= C_PC_RESET;
      r_pend_tgt <= C_PC_RESET;
      r_instr    <= C_NOP_INSTR;
      r_pc_add2  <= 16'h0000;
      r_valid    <= 1'b0;
`ifdef FETCH_HALT_EN
      r_halted   <= 1'b0;
`endif
    end else begin
      case (r_state)
        RUN: begin
`ifdef FETCH_HALT_EN
          if (w_halt_req) begin
            r_state   <= HALTED;
            r_halted  <= 1'b1;
            r_instr   <= C_NOP_INSTR;
            r_pc_add2 <= 16'h0000;
            r_valid   <= 1'b0;
          end else
`endif
          if (w_redirect) begin
            r_instr   <= C_NOP_INSTR;
            r_pc_add2 <= 16'h0000;
            r_valid   <= 1'b0;
            if (imem_stall) begin
              // Memory is busy with the wrong-path fetch; remember the target.
              r_pend_tgt <= pc_jump_out;
              r_state    <= PEND;
            end else begin
              r_pc <= pc_jump_out;
            end
          end else if (stall) begin
            r_pc <= r_pc;
          end else if (imem_stall) begin
            r_instr   <= C_NOP_INSTR;
            r_pc_add2 <= 16'h0000;
            r_valid   <= 1'b0;
          end else begin
            r_instr   <= imem_instr;
            r_pc_add2 <= w_pc_add2;
            r_valid   <= 1'b1;
            r_pc      <= w_pc_add2;
          end
        end

        PEND: begin
          // The word returned when memory frees up belongs to the old path.
          r_instr   <= C_NOP_INSTR;
          r_pc_add2 <= 16'h0000;
          r_valid   <= 1'b0;
          if (!imem_stall) begin
            r_pc    <= r_pend_tgt;
            r_state <= RUN;
          end
        end

`ifdef FETCH_HALT_EN
        HALTED: begin
          r_instr   <= C_NOP_INSTR;
          r_pc_add2 <= 16'h0000;
          r_valid   <= 1'b0;
          r_halted  <= 1'b1;
        end
`endif

        default: begin
          r_state   <= RUN;
          r_instr   <= C_NOP_INSTR;
          r_pc_add2 <= 16'h0000;
          r_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
